// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing the single-ported CPU memory between instruction fetch and load/store.
// Optional build macro: MEMARB_RR_EN selects round-robin arbitration instead of data-over-fetch priority.
module mem_port_arbiter #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_valid,
    output logic [31:0] data_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] CNT_RD = 3'(RD_LAT - 1);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        owner_data_q;
    logic        we_q;
    logic        mem_wr_q;
    logic        fvalid_q, dvalid_q;
    logic [31:0] addr_q, wdata_q, fdata_q, drdata_q;

    logic        data_first;
    logic        data_win;
    logic        any_req;
    logic        win_we;

`ifdef MEMARB_RR_EN
    logic        last_data_q;
    assign data_first = ~last_data_q;
`else
    assign data_first = 1'b1;
`endif

    assign any_req  = fetch_req | data_req;
    assign data_win = data_req & (~fetch_req | data_first);
    assign win_we   = data_win & data_we;

    // Grants are combinational but must stay low while reset is asserted.
    assign data_gnt  = reset & (state_q == IDLE) & data_win;
    assign fetch_gnt = reset & (state_q == IDLE) & fetch_req & ~data_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_data_q <= 1'b0;
            we_q         <= 1'b0;
            mem_wr_q     <= 1'b0;
            fvalid_q     <= 1'b0;
            dvalid_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            fdata_q      <= '0;
            drdata_q     <= '0;
`ifdef MEMARB_RR_EN
            last_data_q  <= 1'b1;
`endif
        end else begin
            mem_wr_q <= 1'b0;
            fvalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_data_q <= data_win;
                        we_q         <= win_we;
                        mem_wr_q     <= win_we;
                        addr_q       <= data_win ? data_addr : fetch_addr;
                        if (data_win)
                            wdata_q  <= data_wdata;
                        cnt_q        <= win_we ? 3'd0 : CNT_RD;
                        state_q      <= ACCESS;
`ifdef MEMARB_RR_EN
                        last_data_q  <= data_win;
`endif
                    end
                end
                ACCESS: begin
                    // Last access cycle: mem_rdata is valid now for reads.
                    if (cnt_q == 3'd0) begin
                        if (!we_q) begin
                            if (owner_data_q)
                                drdata_q <= mem_rdata;
                            else
                                fdata_q  <= mem_rdata;
                        end
                        fvalid_q <= ~owner_data_q;
                        dvalid_q <= owner_data_q;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wr      = mem_wr_q;
    assign fetch_valid = fvalid_q;
    assign data_valid  = dvalid_q;
    assign fetch_data  = fdata_q;
    assign data_rdata  = drdata_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected responses, a monitor pops them on valid.
module tb_mem_port_arbiter;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_gnt, fetch_valid;
    logic [31:0] fetch_data;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_gnt, data_valid;
    logic [31:0] data_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, busy;

    mem_port_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_valid(data_valid),
        .data_rdata(data_rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Small memory: fixed words plus one writable location at 0x100.
    logic [31:0] st_word = 32'h0;
    always @(posedge clk)
        if (reset && mem_wr && mem_addr == 32'h100) st_word <= mem_wdata;
    assign mem_rdata = (mem_addr == 32'h4)   ? 32'h8C220010 :
                       (mem_addr == 32'h8)   ? 32'h00000013 :
                       (mem_addr == 32'h200) ? 32'h12345678 :
                       (mem_addr == 32'h100) ? st_word      : 32'hFFFFFFFF;

    typedef struct {
        bit          is_data;
        logic [31:0] f;
        logic [31:0] d;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_f = '0;
    logic [31:0] exp_d = '0;
    bit          last_data = 1'b1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void push_exp(input bit is_data, input bit is_read, input logic [31:0] v, input int t);
        exp_t e;
        if (is_read) begin
            if (is_data) exp_d = v;
            else         exp_f = v;
        end
        e.is_data = is_data;
        e.f       = exp_f;
        e.d       = exp_d;
        e.cyc     = t + (is_read ? RD_LAT + 1 : 2);
        sb.push_back(e);
        last_data = is_data;
    endfunction

    // Monitor: every valid pulse must match the oldest expected response.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && (fetch_valid || data_valid)) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_valid: fetch_valid=%b data_valid=%b with nothing pending",
                         fetch_valid, data_valid);
            end else begin
                e = sb.pop_front();
                chk("valid_kind", {30'b0, fetch_valid, data_valid}, e.is_data ? 32'd1 : 32'd2);
                chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                chk("fetch_data", fetch_data, e.f);
                chk("data_rdata", data_rdata, e.d);
            end
        end
    end

    task automatic wait_gnt(input bit want_data, output int t);
        bit got = 1'b0;
        t = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (fetch_gnt || data_gnt) got = 1'b1;
        end
        if (!got) begin
            n_chk++;
            $display("FAIL gnt_timeout: no grant within 20 cycles, required %s", want_data ? "data" : "fetch");
        end else begin
            chk("gnt_sel", {30'b0, fetch_gnt, data_gnt}, want_data ? 32'd1 : 32'd2);
            t = cyc;
        end
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, output int t);
        @(posedge clk); #1;
        fetch_req = 1'b1; fetch_addr = addr;
        wait_gnt(1'b0, t);
        if (t >= 0) push_exp(data_gnt, 1'b1, word, t);
        @(posedge clk); #1;
        fetch_req = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] word, output int t);
        @(posedge clk); #1;
        data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wd;
        wait_gnt(1'b1, t);
        if (t >= 0) push_exp(data_gnt, !we, word, t);
        @(posedge clk); #1;
        data_req = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_wr"}, {31'b0, mem_wr}, 32'd0);
        chk({tag, "_fetch_data"}, fetch_data, 32'd0);
        chk({tag, "_data_rdata"}, data_rdata, 32'd0);
        chk({tag, "_valids"}, {30'b0, fetch_valid, data_valid}, 32'd0);
        chk({tag, "_gnts"}, {30'b0, fetch_gnt, data_gnt}, 32'd0);
    endtask

    initial begin : global_timeout
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t, t1, t2, tprev;
        bit w;
        // Reset state, with requests high to show grants are suppressed.
        fetch_req = 1'b1; data_req = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("rst");
        fetch_req = 1'b0; data_req = 1'b0;
        @(posedge clk); #1 reset = 1'b1;

        // Fetch read with bus/busy timing.
        do_fetch(32'h4, 32'h8C220010, t);
        @(negedge clk);
        chk("f_mem_addr_t1", mem_addr, 32'h4);
        chk("f_busy_t1", {31'b0, busy}, 32'd1);
        chk("f_mem_wr_t1", {31'b0, mem_wr}, 32'd0);
        @(negedge clk);
        chk("f_mem_addr_t2", mem_addr, 32'h4);
        @(negedge clk);
        chk("f_busy_t3", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("f_busy_t4", {31'b0, busy}, 32'd0);

        // Store: single-cycle write strobe.
        do_data(1'b1, 32'h100, 32'hDEADBEEF, 32'h0, t);
        @(negedge clk);
        chk("st_mem_wr_t1", {31'b0, mem_wr}, 32'd1);
        chk("st_mem_addr", mem_addr, 32'h100);
        chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("st_mem_wr_t2", {31'b0, mem_wr}, 32'd0);

        // Load back the stored word.
        do_data(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, t);

        // Simultaneous requests.
`ifdef MEMARB_RR_EN
        w = !last_data;
`else
        w = 1'b1;
`endif
        @(posedge clk); #1;
        fetch_req = 1'b1; fetch_addr = 32'h8;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h200;
        wait_gnt(w, t1);
        if (t1 >= 0) push_exp(data_gnt, 1'b1, data_gnt ? 32'h12345678 : 32'h00000013, t1);
        @(posedge clk); #1;
        if (w) data_req = 1'b0; else fetch_req = 1'b0;
        wait_gnt(!w, t2);
        if (t2 >= 0) push_exp(data_gnt, 1'b1, data_gnt ? 32'h12345678 : 32'h00000013, t2);
        chk("second_gnt_spacing", 32'(t2 - t1), 32'(RD_LAT + 2));
        @(posedge clk); #1;
        fetch_req = 1'b0; data_req = 1'b0;

        // Both requests held for four grants, after a fetch.
        do_fetch(32'h4, 32'h8C220010, t);
        @(posedge clk); #1;
        fetch_req = 1'b1; fetch_addr = 32'h8;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h200;
        tprev = -1;
        for (int i = 0; i < 4; i++) begin
`ifdef MEMARB_RR_EN
            w = !last_data;
`else
            w = 1'b1;
`endif
            wait_gnt(w, t);
            if (t >= 0) begin
                push_exp(data_gnt, 1'b1, data_gnt ? 32'h12345678 : 32'h00000013, t);
                if (tprev >= 0) chk("hold_gnt_spacing", 32'(t - tprev), 32'(RD_LAT + 2));
                tprev = t;
            end
        end
        @(posedge clk); #1;
        fetch_req = 1'b0; data_req = 1'b0;

        // Reset in the middle of a read: abandoned, no valid pulse.
        @(posedge clk); #1;
        fetch_req = 1'b1; fetch_addr = 32'h8;
        wait_gnt(1'b0, t);
        @(posedge clk); #1;
        reset = 1'b0;
        #1 chk_reset_outputs("midrst");
        fetch_req = 1'b0;
        exp_f = '0; exp_d = '0; last_data = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        do_fetch(32'h4, 32'h8C220010, t);

        repeat (10) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
